// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W      = 10;
    localparam int DMEM_DATA_W      = 64;
    localparam int BYTES_PER_ACCESS = 8;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // True when a doubleword access is unaligned or would run past the top of memory.
    function automatic logic addr_out_of_bounds(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[2:0] != 3'd0) ||
               (addr > ((32'd1 << addr_w) - 32'(BYTES_PER_ACCESS)));
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response channel of one arbiter port (core LSU or debug loader).
interface dmem_req_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on contention the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       next_last_grant
);

    // Grant selection and the last-grant value to remember after this pick.
    always_comb begin
        gnt             = 2'b00;
        next_last_grant = last_grant;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
        if (gnt[1]) begin
            next_last_grant = 1'b1;
        end else if (gnt[0]) begin
            next_last_grant = 1'b0;
        end else begin
            next_last_grant = last_grant;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core/loader doubleword requests onto the single data memory.
// Optional DMEM_ARB_ALIGN_CHECK_EN rejects unaligned/out-of-range accesses with rsp_err.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    dmem_req_if.slave         p0,
    dmem_req_if.slave         p1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    arb_state_e        state_r, state_s;
    logic              last_grant_r, next_last_s;
    logic [1:0]        gnt_s;
    logic              arb_en_s, accept_s;
    logic              sel_we_s, sel_bad_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              we_r, port_r, bad_r, err_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r, rdata_r;

    assign arb_en_s = (state_r == IDLE);
    assign accept_s = |gnt_s;

    rr_arb2 u_rr_arb2 (
        .req             ({p1.req_valid, p0.req_valid}),
        .last_grant      (last_grant_r),
        .en              (arb_en_s),
        .gnt             (gnt_s),
        .next_last_grant (next_last_s)
    );

    // Mux the winning port's request fields.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (gnt_s[1]) begin
            sel_we_s    = p1.req_we;
            sel_addr_s  = p1.req_addr;
            sel_wdata_s = p1.req_wdata;
        end else begin
            sel_we_s    = p0.req_we;
            sel_addr_s  = p0.req_addr;
            sel_wdata_s = p0.req_wdata;
        end
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign sel_bad_s = addr_out_of_bounds(32'(sel_addr_s), ADDR_W);
`else
    assign sel_bad_s = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS:  state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight access immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch the accepted request and remember who won.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_r         <= 1'b0;
            port_r       <= PORT_CORE;
            bad_r        <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            last_grant_r <= PORT_LOAD;
        end else if (accept_s) begin
            we_r         <= sel_we_s;
            port_r       <= gnt_s[1] ? PORT_LOAD : PORT_CORE;
            bad_r        <= sel_bad_s;
            addr_r       <= sel_addr_s;
            wdata_r      <= sel_wdata_s;
            last_grant_r <= next_last_s;
        end
    end

    // Capture the response at the end of the memory cycle; held until the next access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= '0;
            err_r   <= 1'b0;
        end else if (state_r == ACCESS) begin
            rdata_r <= (we_r || bad_r) ? '0 : mem_read_data;
            err_r   <= bad_r;
        end
    end

    // Memory controls are decoded from state so reset drops them without a clock edge.
    assign mem_address    = addr_r;
    assign mem_write_data = wdata_r;
    assign mem_write      = (state_r == ACCESS) && we_r && !bad_r;
    assign mem_read       = (state_r == ACCESS) && !we_r && !bad_r;
    assign busy           = (state_r != IDLE);

    assign p0.req_ready = gnt_s[0];
    assign p1.req_ready = gnt_s[1];
    assign p0.rsp_valid = (state_r == RESP) && (port_r == PORT_CORE);
    assign p1.rsp_valid = (state_r == RESP) && (port_r == PORT_LOAD);
    assign p0.rsp_rdata = rdata_r;
    assign p1.rsp_rdata = rdata_r;
    assign p0.rsp_err   = err_r;
    assign p1.rsp_err   = err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a byte-array memory model and a round-robin grant model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fill;
    logic [9:0]  mem_address;
    logic [63:0] mem_write_data;
    logic        mem_read, mem_write, busy;
    logic [63:0] mem_read_data;

    logic [7:0]  env_mem [1024];
    logic [7:0]  ref_mem [1024];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic        pend  [2];
    logic        t_we  [2];
    logic [9:0]  t_addr[2];
    logic [63:0] t_wd  [2];
    int          m_last;

    dmem_req_if p0_if ();
    dmem_req_if p1_if ();

    dmem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .p0             (p0_if),
        .p1             (p1_if),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 29 + 7) ^ (i >> 3));
    endfunction

    // Big-endian 1 KiB memory seen by the arbiter.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 1024; i++) env_mem[i] <= init_byte(i);
        end else if (mem_write) begin
            for (int b = 0; b < 8; b++) env_mem[mem_address + 10'(b)] <= mem_write_data[63-8*b -: 8];
        end
    end

    always_comb begin
        mem_read_data = 64'd0;
        for (int b = 0; b < 8; b++) mem_read_data[63-8*b -: 8] = env_mem[mem_address + 10'(b)];
    end

    function automatic logic [63:0] ref_read(logic [9:0] a);
        logic [63:0] r = 64'd0;
        for (int b = 0; b < 8; b++) r = {r[55:0], ref_mem[a + 10'(b)]};
        return r;
    endfunction

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    function automatic logic tb_bad(logic [9:0] a);
        return ((int'(a) % 8) != 0) || (int'(a) > 1024 - 8);
    endfunction
`endif

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        p0_if.req_valid = pend[0]; p0_if.req_we = t_we[0];
        p0_if.req_addr  = t_addr[0]; p0_if.req_wdata = t_wd[0];
        p1_if.req_valid = pend[1]; p1_if.req_we = t_we[1];
        p1_if.req_addr  = t_addr[1]; p1_if.req_wdata = t_wd[1];
    endtask

    task automatic set_req(int p, logic we, logic [9:0] a, logic [63:0] d);
        pend[p] = 1'b1; t_we[p] = we; t_addr[p] = a; t_wd[p] = d;
    endtask

    // One complete transaction from IDLE: handshake, memory cycle, response.
    task automatic serve_one(output int w, output int resp_cyc);
        logic bad;
        logic [63:0] exp;
        drive();
        #1;
        w = (pend[0] && pend[1]) ? ((m_last == 1) ? 0 : 1) : (pend[0] ? 0 : 1);
        chk("ready0", 64'(p0_if.req_ready), 64'(w == 0));
        chk("ready1", 64'(p1_if.req_ready), 64'(w == 1));
        tick();
        m_last = w;
        pend[w] = 1'b0;
        drive();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        bad = tb_bad(t_addr[w]);
`else
        bad = 1'b0;
`endif
        chk("acc_mem_write", 64'(mem_write), 64'(t_we[w] && !bad));
        chk("acc_mem_read", 64'(mem_read), 64'(!t_we[w] && !bad));
        chk("acc_addr", 64'(mem_address), 64'(t_addr[w]));
        chk("acc_busy", 64'(busy), 64'd1);
        chk("acc_ready", 64'({p1_if.req_ready, p0_if.req_ready}), 64'd0);
        chk("acc_rsp_valid", 64'({p1_if.rsp_valid, p0_if.rsp_valid}), 64'd0);
        if (t_we[w] && !bad) chk("acc_wdata", mem_write_data, t_wd[w]);
        exp = (t_we[w] || bad) ? 64'd0 : ref_read(t_addr[w]);
        if (t_we[w] && !bad)
            for (int b = 0; b < 8; b++) ref_mem[t_addr[w] + 10'(b)] = t_wd[w][63-8*b -: 8];
        tick();
        resp_cyc = cyc;
        chk("rsp_valid0", 64'(p0_if.rsp_valid), 64'(w == 0));
        chk("rsp_valid1", 64'(p1_if.rsp_valid), 64'(w == 1));
        chk("rsp_rdata", (w == 0) ? p0_if.rsp_rdata : p1_if.rsp_rdata, exp);
        chk("rsp_err", 64'((w == 0) ? p0_if.rsp_err : p1_if.rsp_err), 64'(bad));
        chk("rsp_mem_ctl", 64'({mem_read, mem_write}), 64'd0);
        tick();
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int w, rc, w2, rc2;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; t_we[p] = 1'b0; t_addr[p] = 10'd0; t_wd[p] = 64'd0;
        end
        drive();
        m_last = 1;
        reset = 1'b0;
        fill  = 1'b1;
        tick();
        tick();
        fill = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_ctl", 64'({mem_read, mem_write}), 64'd0);
        chk("rst_mem_addr", 64'(mem_address), 64'd0);
        chk("rst_mem_wdata", mem_write_data, 64'd0);
        chk("rst_rsp", 64'({p1_if.rsp_valid, p0_if.rsp_valid, p1_if.rsp_err, p0_if.rsp_err}), 64'd0);
        chk("rst_rdata", p0_if.rsp_rdata, 64'd0);
        reset = 1'b1;
        tick();

        // Contention straight after reset: port 0 first, port 1 next, 3 cycles apart.
        set_req(0, 1'b0, 10'h000, 64'd0);
        set_req(1, 1'b0, 10'h008, 64'd0);
        serve_one(w, rc);
        chk("cont_first", 64'(w), 64'd0);
        serve_one(w2, rc2);
        chk("cont_second", 64'(w2), 64'd1);
        chk("cont_gap", 64'(rc2 - rc), 64'd3);

        // Write then read back the same doubleword on port 0.
        set_req(0, 1'b1, 10'h010, 64'h0123456789ABCDEF);
        serve_one(w, rc);
        set_req(0, 1'b0, 10'h010, 64'd0);
        serve_one(w, rc);
        chk("wr_rd_literal", p0_if.rsp_rdata, 64'h0123456789ABCDEF);

        // Port 1 stays valid while port 0 keeps requesting: grants must alternate.
        for (int k = 0; k < 6; k++) begin
            if (!pend[0]) set_req(0, 1'($urandom_range(0, 1)), {7'($urandom_range(0, 127)), 3'b000}, {$urandom, $urandom});
            if (!pend[1]) set_req(1, 1'($urandom_range(0, 1)), {7'($urandom_range(0, 127)), 3'b000}, {$urandom, $urandom});
            serve_one(w, rc);
            if (k > 0) chk("alternate", 64'(w), 64'(1 - w2));
            w2 = w;
        end
        while (pend[0] || pend[1]) serve_one(w, rc);

        // Unaligned / top-of-memory accesses.
        set_req(0, 1'b1, 10'h3FC, 64'hA5A5_5A5A_0F0F_F0F0);
        serve_one(w, rc);
        set_req(0, 1'b0, 10'h003, 64'd0);
        serve_one(w, rc);

        // Randomized mixed traffic on both ports.
        for (int k = 0; k < 60; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 2) != 0)) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(p, 1'($urandom_range(0, 1)), 10'($urandom), {$urandom, $urandom});
                    else
                        set_req(p, 1'($urandom_range(0, 1)), {7'($urandom_range(0, 127)), 3'b000}, {$urandom, $urandom});
                end
            end
            if (pend[0] || pend[1]) begin
                serve_one(w, rc);
            end else begin
                drive();
                #1;
                chk("idle_ready", 64'({p1_if.req_ready, p0_if.req_ready}), 64'd0);
                chk("idle_mem_ctl", 64'({mem_read, mem_write}), 64'd0);
                tick();
            end
        end
        while (pend[0] || pend[1]) serve_one(w, rc);

        // Reset during the memory cycle of a write: no commit, no response.
        set_req(0, 1'b1, 10'h020, 64'hFFFF_FFFF_FFFF_FFFF);
        drive();
        #1;
        chk("rst_mid_ready", 64'(p0_if.req_ready), 64'd1);
        tick();
        chk("rst_mid_write_hi", 64'(mem_write), 64'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_write_lo", 64'(mem_write), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        pend[0] = 1'b0;
        drive();
        tick();
        chk("rst_mid_rsp", 64'({p1_if.rsp_valid, p0_if.rsp_valid}), 64'd0);
        reset = 1'b1;
        m_last = 1;
        tick();
        chk("rst_mid_rsp2", 64'({p1_if.rsp_valid, p0_if.rsp_valid}), 64'd0);
        set_req(0, 1'b0, 10'h020, 64'd0);
        serve_one(w, rc);
        chk("rst_mid_nocommit", 64'(p0_if.rsp_rdata == 64'hFFFF_FFFF_FFFF_FFFF), 64'(ref_read(10'h020) == 64'hFFFF_FFFF_FFFF_FFFF));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
